// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit sitting directly in front of the data RAM.
// It takes one request per cycle, drives the RAM port in the same cycle, formats
// the one-cycle-late read data, and returns a response through a small
// response/hold stage with valid/ready handshaking.
module mem_lsu #(
    parameter int unsigned MEM_AW = 12
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_is_load,
    output logic [4:0]        rsp_rd,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [3:0]        ram_wem,
    output logic [MEM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RESP = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        is_load_q, is_load_d;
    logic [4:0]  rd_q, rd_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic        err_q, err_d;
    logic [31:0] hold_q, hold_d;

    logic        acc;
    logic        err;
    logic [31:0] lane;
    logic [31:0] fmt;

    // Address bits above the RAM window are intentionally ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:MEM_AW+2];

    // Request legality: illegal widths and misaligned halfword/word accesses.
    always_comb begin
        err = 1'b0;
        if (req_we) begin
            case (req_funct3[1:0])
                2'b00:   err = 1'b0;
                2'b01:   err = req_addr[0];
                2'b10:   err = |req_addr[1:0];
                default: err = 1'b1;
            endcase
        end else begin
            case (req_funct3)
                3'b000, 3'b100: err = 1'b0;
                3'b001, 3'b101: err = req_addr[0];
                3'b010:         err = |req_addr[1:0];
                default:        err = 1'b1;
            endcase
        end
    end

    // RAM port drive in the accept cycle: select, byte mask, lane-replicated data.
    always_comb begin
        acc       = req_valid & req_ready;
        ram_cs    = acc & ~err;
        ram_we    = ram_cs & req_we;
        ram_addr  = req_addr[MEM_AW+1:2];
        ram_wem   = '0;
        ram_wdata = req_wdata;
        case (req_funct3[1:0])
            2'b00:   ram_wdata = {4{req_wdata[7:0]}};
            2'b01:   ram_wdata = {2{req_wdata[15:0]}};
            default: ram_wdata = req_wdata;
        endcase
        if (ram_we) begin
            case (req_funct3[1:0])
                2'b00:   ram_wem = 4'b0001 << req_addr[1:0];
                2'b01:   ram_wem = 4'b0011 << req_addr[1:0];
                default: ram_wem = 4'b1111;
            endcase
        end
    end

    // Load formatting of the live RAM read data using the captured request info.
    always_comb begin
        lane = ram_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  fmt = {{24{lane[7]}}, lane[7:0]};
            3'b100:  fmt = {24'b0, lane[7:0]};
            3'b001:  fmt = {{16{lane[15]}}, lane[15:0]};
            3'b101:  fmt = {16'b0, lane[15:0]};
            3'b010:  fmt = lane;
            default: fmt = '0;
        endcase
        if (!is_load_q || err_q) begin
            fmt = '0;
        end
    end

    // Response FSM: next state, request capture, hold capture and handshake outputs.
    always_comb begin
        state_d     = state_q;
        is_load_d   = is_load_q;
        rd_d        = rd_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        err_d       = err_q;
        hold_d      = hold_q;
        rsp_valid   = 1'b0;
        req_ready   = 1'b0;
        rsp_rdata   = '0;

        case (state_q)
            IDLE: begin
                req_ready = rstn;
                if (acc) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = fmt;
                req_ready = rstn & rsp_ready;
                if (!rsp_ready) begin
                    state_d = HOLD;
                    hold_d  = fmt;
                end else if (acc) begin
                    state_d = RESP;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                rsp_valid = 1'b1;
                rsp_rdata = hold_q;
                req_ready = rstn & rsp_ready;
                if (!rsp_ready) begin
                    state_d = HOLD;
                end else if (acc) begin
                    state_d = RESP;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (acc) begin
            is_load_d = ~req_we;
            rd_d      = req_rd;
            funct3_d  = req_funct3;
            off_d     = req_addr[1:0];
            err_d     = err;
        end

        rsp_is_load = rsp_valid & is_load_q;
        rsp_err     = rsp_valid & err_q;
        rsp_rd      = (rsp_valid & is_load_q & ~err_q) ? rd_q : '0;
    end

    // State and response registers; reset discards any pending response.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            is_load_q <= 1'b0;
            rd_q      <= '0;
            funct3_q  <= '0;
            off_q     <= '0;
            err_q     <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            is_load_q <= is_load_d;
            rd_q      <= rd_d;
            funct3_q  <= funct3_d;
            off_q     <= off_d;
            err_q     <= err_d;
            hold_q    <= hold_d;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed bench for mem_lsu with a behavioural RAM, a response
// scoreboard queue and an independent monitor that pops on each handshake.
module tb_mem_lsu;

    typedef struct packed {
        logic        is_load;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_is_load;
    logic [4:0]  rsp_rd;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        ram_cs;
    logic        ram_we;
    logic [3:0]  ram_wem;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int   checks;
    int   failures;
    rsp_t exp_q[$];

    logic [31:0] mem [0:4095];
    logic [31:0] ram_q;
    logic        perturb;
    logic [31:0] pert_val;

    mem_lsu #(.MEM_AW(12)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(req_rd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_is_load(rsp_is_load),
        .rsp_rd(rsp_rd), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_wem(ram_wem),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM with byte mask and 1-cycle read latency.
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_wem[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
                end
            end else begin
                ram_q <= mem[ram_addr];
            end
        end
    end
    assign ram_rdata = perturb ? pert_val : ram_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compare each handshaken response against the scoreboard head.
    always @(negedge clk) begin
        if (rstn && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp: got rd=%0d rdata=0x%08h expected none", rsp_rd, rsp_rdata);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                chk("rsp_is_load", {31'b0, rsp_is_load}, {31'b0, e.is_load});
                chk("rsp_rd", {27'b0, rsp_rd}, {27'b0, e.rd});
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
            end
        end
    end

    // Issue one request at posedge+1, check the RAM drive, queue the expected response.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd,
                          input logic e_cs, input logic [3:0] e_wem, input logic [31:0] e_wdata,
                          input logic [31:0] e_rdata, input logic e_err);
        rsp_t e;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rd     = rd;
        #1;
        chk("req_ready", {31'b0, req_ready}, 32'd1);
        chk("ram_cs", {31'b0, ram_cs}, {31'b0, e_cs});
        chk("ram_we", {31'b0, ram_we}, {31'b0, e_cs & we});
        chk("ram_wem", {28'b0, ram_wem}, {28'b0, e_wem});
        if (e_cs) chk("ram_addr", {20'b0, ram_addr}, {20'b0, addr[13:2]});
        if (e_cs && we) chk("ram_wdata", ram_wdata, e_wdata);
        e.is_load = ~we;
        e.rd      = (we || e_err) ? 5'd0 : rd;
        e.rdata   = e_rdata;
        e.err     = e_err;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        perturb    = 1'b0;
        pert_val   = '0;
        ram_q      = '0;
        rstn       = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        req_wdata  = '0;
        req_rd     = 5'd1;
        rsp_ready  = 1'b1;
        for (int i = 0; i < 4096; i++) mem[i] = '0;

        // Reset state.
        #2;
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_ram_cs", {31'b0, ram_cs}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
        chk("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Word store then load.
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0, 1'b1, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd5, 1'b1, 4'b0000, 32'h0, 32'hDEADBEEF, 1'b0);
        // Sub-word loads from 0xDEADBEEF, back to back.
        do_req(1'b0, 3'b000, 32'h13, 32'h0, 5'd6, 1'b1, 4'b0000, 32'h0, 32'hFFFFFFDE, 1'b0);
        do_req(1'b0, 3'b100, 32'h13, 32'h0, 5'd7, 1'b1, 4'b0000, 32'h0, 32'h000000DE, 1'b0);
        do_req(1'b0, 3'b001, 32'h12, 32'h0, 5'd8, 1'b1, 4'b0000, 32'h0, 32'hFFFFDEAD, 1'b0);
        do_req(1'b0, 3'b101, 32'h10, 32'h0, 5'd9, 1'b1, 4'b0000, 32'h0, 32'h0000BEEF, 1'b0);
        do_req(1'b0, 3'b000, 32'h10, 32'h0, 5'd10, 1'b1, 4'b0000, 32'h0, 32'hFFFFFFEF, 1'b0);
        // Error cases: misaligned LH, illegal funct3, misaligned SW.
        do_req(1'b0, 3'b001, 32'h11, 32'h0, 5'd11, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
        do_req(1'b0, 3'b011, 32'h10, 32'h0, 5'd12, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
        do_req(1'b1, 3'b010, 32'h12, 32'h11111111, 5'd0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
        drain();

        // Backpressure: response captured, then held against a perturbed RAM bus.
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd13, 1'b1, 4'b0000, 32'h0, 32'hDEADBEEF, 1'b0);
        rsp_ready  = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h13;
        req_rd     = 5'd14;
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            perturb  = 1'b1;
            pert_val = $urandom;
            #1;
            chk("hold_rdata", rsp_rdata, 32'hDEADBEEF);
            chk("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
            chk("hold_ram_cs", {31'b0, ram_cs}, 32'd0);
            @(posedge clk);
            #1;
        end
        perturb   = 1'b0;
        rsp_ready = 1'b1;
        do_req(1'b0, 3'b000, 32'h13, 32'h0, 5'd14, 1'b1, 4'b0000, 32'h0, 32'hFFFFFFDE, 1'b0);
        drain();

        // Byte and halfword stores.
        do_req(1'b1, 3'b000, 32'h11, 32'h123456AA, 5'd0, 1'b1, 4'b0010, 32'hAAAAAAAA, 32'h0, 1'b0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd15, 1'b1, 4'b0000, 32'h0, 32'hDEADAAEF, 1'b0);
        do_req(1'b1, 3'b001, 32'h12, 32'h00005555, 5'd0, 1'b1, 4'b1100, 32'h55555555, 32'h0, 1'b0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd16, 1'b1, 4'b0000, 32'h0, 32'h5555AAEF, 1'b0);
        drain();

        // Asynchronous reset while a response is presented.
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd3, 1'b1, 4'b0000, 32'h0, 32'h5555AAEF, 1'b0);
        chk("pre_rst_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        rstn      = 1'b0;
        req_valid = 1'b1;
        #1;
        exp_q.delete();
        chk("async_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("async_rst_ram_cs", {31'b0, ram_cs}, 32'd0);
        chk("async_rst_req_ready", {31'b0, req_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        req_valid = 1'b0;
        rstn      = 1'b1;
        #1;
        chk("rel_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rel_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd9, 1'b1, 4'b0000, 32'h0, 32'h5555AAEF, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
